sdram_rd_burst: RTL

SDRAM_RD_BURST -- requirements
Module: sdram_rd_burst

---
 rtl/sdram_rd_burst_if.sv | 30 +++
 rtl/sdram_rd_burst.sv | 177 +++++++++++++++++
 2 files changed

// File: rtl/sdram_rd_burst_if.sv
// Signal bundle between the SDRAM read-burst engine, its arbiter and the SDRAM pins.
// The engine drives through master; the arbiter/memory side uses slave.
interface sdram_rd_burst_if #(
    parameter int DQ_W   = 16,
    parameter int ROW_W  = 12,
    parameter int BANK_W = 2
);
    logic              rd_en;
    logic              ref_req;
    logic              key_rd;
    logic [DQ_W-1:0]   rd_dq;
    logic [3:0]        sdram_cmd;
    logic [ROW_W-1:0]  sdram_addr;
    logic [BANK_W-1:0] sdram_bank;
    logic              rd_req;
    logic              flag_rd_end;
    logic [DQ_W-1:0]   rd_data;
    logic              rd_valid;
    logic              busy;

    modport master (
        input  rd_en, ref_req, key_rd, rd_dq,
        output sdram_cmd, sdram_addr, sdram_bank, rd_req, flag_rd_end, rd_data, rd_valid, busy
    );

    modport slave (
        output rd_en, ref_req, key_rd, rd_dq,
        input  sdram_cmd, sdram_addr, sdram_bank, rd_req, flag_rd_end, rd_data, rd_valid, busy
    );
endinterface

// File: rtl/sdram_rd_burst.sv
// SDRAM read-burst engine: PRE/ACT only when the target row is not already open,
// then RD, CAS wait and BURST_LEN captured words; the {bank,row,col} pointer advances per burst.
module sdram_rd_burst #(
    parameter int DQ_W      = 16,
    parameter int ROW_W     = 12,
    parameter int COL_W     = 9,
    parameter int BANK_W    = 2,
    parameter int BURST_LEN = 4,
    parameter int CAS_LAT   = 3,
    parameter int T_RP      = 2,
    parameter int T_RCD     = 2
) (
    input  logic             sclk,
    input  logic             s_rst_n,
    sdram_rd_burst_if.master bus
);
    localparam logic [3:0] CMD_NOP = 4'b0111;
    localparam logic [3:0] CMD_PRE = 4'b0010;
    localparam logic [3:0] CMD_ACT = 4'b0011;
    localparam logic [3:0] CMD_RD  = 4'b0101;
    localparam int CNT_W = 8;
    // A10 high selects precharge-all; collapses to zero on narrow test buses.
    localparam logic [ROW_W-1:0] A10_ALL = ROW_W'(1 << 10);

    typedef enum logic [3:0] {
        S_IDLE, S_PRE, S_TRP_W, S_ACT, S_TRCD_W, S_RD, S_CAS_W, S_DATA, S_END
    } state_t;

    state_t            state_q, state_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic [3:0]        cmd_q, cmd_d;
    logic [ROW_W-1:0]  sdram_addr_q, sdram_addr_d;
    logic [BANK_W-1:0] sdram_bank_q, sdram_bank_d;
    logic              rd_req_q, rd_req_d;
    logic              flag_rd_end_q, flag_rd_end_d;
    logic [DQ_W-1:0]   rd_data_q, rd_data_d;
    logic              rd_valid_q, rd_valid_d;
    logic              busy_q, busy_d;
    logic              pending_q, pending_d;
    logic              row_open_q, row_open_d;
    logic [BANK_W-1:0] open_bank_q, open_bank_d;
    logic [ROW_W-1:0]  open_row_q, open_row_d;
    logic [COL_W-1:0]  col_q, col_d;
    logic [ROW_W-1:0]  row_q, row_d;
    logic [BANK_W-1:0] bank_q, bank_d;
    logic [COL_W:0]    col_sum;
    logic              row_hit;

    always_comb begin
        state_d     = state_q;
        cnt_d       = '0;
        row_open_d  = row_open_q;
        open_bank_d = open_bank_q;
        open_row_d  = open_row_q;
        col_d       = col_q;
        row_d       = row_q;
        bank_d      = bank_q;
        col_sum     = {1'b0, col_q} + (COL_W+1)'(BURST_LEN);
        row_hit     = row_open_q && (open_bank_q == bank_q) && (open_row_q == row_q);

        case (state_q)
            S_IDLE:   if (bus.rd_en) state_d = row_hit ? S_RD : S_PRE;
            S_PRE:    state_d = (T_RP > 1) ? S_TRP_W : S_ACT;
            S_TRP_W: begin
                if (cnt_q == CNT_W'(T_RP - 2)) state_d = S_ACT;
                else                           cnt_d = cnt_q + 1'b1;
            end
            S_ACT: begin
                row_open_d  = 1'b1;
                open_bank_d = bank_q;
                open_row_d  = row_q;
                state_d     = (T_RCD > 1) ? S_TRCD_W : S_RD;
            end
            S_TRCD_W: begin
                if (cnt_q == CNT_W'(T_RCD - 2)) state_d = S_RD;
                else                            cnt_d = cnt_q + 1'b1;
            end
            S_RD:     state_d = S_CAS_W;
            S_CAS_W: begin
                if (cnt_q == CNT_W'(CAS_LAT - 1)) state_d = S_DATA;
                else                              cnt_d = cnt_q + 1'b1;
            end
            S_DATA: begin
                if (cnt_q == CNT_W'(BURST_LEN - 1)) state_d = S_END;
                else                                cnt_d = cnt_q + 1'b1;
            end
            S_END: begin
                state_d = S_IDLE;
                col_d   = col_sum[COL_W-1:0];
                // Leaving the row invalidates the open-row record.
                if (col_sum[COL_W]) begin
                    row_d      = row_q + 1'b1;
                    row_open_d = 1'b0;
                    if (&row_q) bank_d = bank_q + 1'b1;
                end
                if (bus.ref_req) row_open_d = 1'b0;
            end
            default:  state_d = S_IDLE;
        endcase

        // Registered outputs are decoded from the next state so they line up with state_q.
        cmd_d        = CMD_NOP;
        sdram_addr_d = row_d;
        sdram_bank_d = bank_d;
        case (state_d)
            S_PRE: begin cmd_d = CMD_PRE; sdram_addr_d = A10_ALL; end
            S_ACT: begin cmd_d = CMD_ACT; sdram_addr_d = row_q; end
            S_RD:  begin cmd_d = CMD_RD;  sdram_addr_d = ROW_W'(col_q); end
            default: ;
        endcase
        busy_d        = (state_d != S_IDLE);
        flag_rd_end_d = (state_d == S_END);
        rd_valid_d    = (state_d == S_DATA);
        rd_data_d     = rd_valid_d ? bus.rd_dq : rd_data_q;

        rd_req_d  = rd_req_q;
        pending_d = pending_q;
        if (bus.key_rd) begin
            if (busy_q) pending_d = 1'b1;
            else        rd_req_d  = 1'b1;
        end
        if (state_q == S_END && pending_d) begin
            rd_req_d  = 1'b1;
            pending_d = 1'b0;
        end
        if (bus.rd_en && state_q == S_IDLE) rd_req_d = 1'b0;
    end

    always_ff @(posedge sclk or negedge s_rst_n) begin
        if (!s_rst_n) begin
            state_q       <= S_IDLE;
            cnt_q         <= '0;
            cmd_q         <= CMD_NOP;
            sdram_addr_q  <= '0;
            sdram_bank_q  <= '0;
            rd_req_q      <= 1'b0;
            flag_rd_end_q <= 1'b0;
            rd_data_q     <= '0;
            rd_valid_q    <= 1'b0;
            busy_q        <= 1'b0;
            pending_q     <= 1'b0;
            row_open_q    <= 1'b0;
            open_bank_q   <= '0;
            open_row_q    <= '0;
            col_q         <= '0;
            row_q         <= '0;
            bank_q        <= '0;
        end else begin
            state_q       <= state_d;
            cnt_q         <= cnt_d;
            cmd_q         <= cmd_d;
            sdram_addr_q  <= sdram_addr_d;
            sdram_bank_q  <= sdram_bank_d;
            rd_req_q      <= rd_req_d;
            flag_rd_end_q <= flag_rd_end_d;
            rd_data_q     <= rd_data_d;
            rd_valid_q    <= rd_valid_d;
            busy_q        <= busy_d;
            pending_q     <= pending_d;
            row_open_q    <= row_open_d;
            open_bank_q   <= open_bank_d;
            open_row_q    <= open_row_d;
            col_q         <= col_d;
            row_q         <= row_d;
            bank_q        <= bank_d;
        end
    end

    assign bus.sdram_cmd   = cmd_q;
    assign bus.sdram_addr  = sdram_addr_q;
    assign bus.sdram_bank  = sdram_bank_q;
    assign bus.rd_req      = rd_req_q;
    assign bus.flag_rd_end = flag_rd_end_q;
    assign bus.rd_data     = rd_data_q;
    assign bus.rd_valid    = rd_valid_q;
    assign bus.busy        = busy_q;
endmodule
